// File: rtl/fetch_unit.sv
// fetch_unit: boot-vectored instruction fetch stage with two-word instruction assembly and IF/ID latch.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   pc_write                   0 holds PC, pending word and FSM
//   stall_fetch                1 holds the IF/ID outputs
//   flush_fetch, branch_target redirect PC and bubble IF/ID (ignored during boot)
//   imem_addr, imem_data       word address out, instruction word back in the same cycle
//   if_id_instr/imm/pc/valid   IF/ID latch contents
//   R_dest_fetch, R_src_fetch  register fields of the latched instruction
//   halted                     high while halted on HLT
//   bubble_count               bubble counter, built only with FETCH_PERF_CNT_EN defined
module fetch_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_write,
    input  logic        stall_fetch,
    input  logic        flush_fetch,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    input  logic [15:0] imem_data,
    output logic [15:0] if_id_instr,
    output logic [15:0] if_id_imm,
    output logic [31:0] if_id_pc,
    output logic        if_id_valid,
    output logic [3:0]  R_dest_fetch,
    output logic [3:0]  R_src_fetch,
    output logic        halted,
    output logic [15:0] bubble_count
);
    typedef enum logic [2:0] {BOOT_HI, BOOT_LO, RUN, IMM, HALTED} state_t;
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, pc_inc;
    logic [15:0] pend_q, pend_d;
    logic [15:0] instr_q, instr_d, imm_q, imm_d;
    logic [31:0] ipc_q, ipc_d;
    logic        valid_q, valid_d;
    logic        active;

    always_comb begin
        pc_inc    = pc_q + 32'd1;
        active    = state_q inside {RUN, IMM, HALTED};
        imem_addr = (state_q == BOOT_HI) ? 32'd0 : (state_q == BOOT_LO) ? 32'd1 : pc_q;
        state_d   = state_q;
        pc_d      = pc_q;
        pend_d    = pend_q;
        instr_d   = instr_q;
        imm_d     = imm_q;
        ipc_d     = ipc_q;
        valid_d   = valid_q;
        if (active && flush_fetch) begin
            state_d = RUN;
            pc_d    = branch_target;
            pend_d  = 16'h0;
            instr_d = 16'h0;
            imm_d   = 16'h0;
            ipc_d   = 32'h0;
            valid_d = 1'b0;
        end else begin
            if (pc_write) begin
                case (state_q)
                    BOOT_HI: begin
                        pc_d    = {imem_data, pc_q[15:0]};
                        state_d = BOOT_LO;
                    end
                    BOOT_LO: begin
                        pc_d    = {pc_q[31:16], imem_data};
                        state_d = RUN;
                    end
                    RUN: begin
                        pc_d = pc_inc;
                        if (imem_data[15]) begin
                            pend_d  = imem_data;
                            state_d = IMM;
                        end else if (imem_data[15:11] == 5'b00001) begin
                            state_d = HALTED;
                        end
                    end
                    IMM: begin
                        pc_d    = pc_inc;
                        state_d = RUN;
                    end
                    default: ;
                endcase
            end
            // A frozen PC with an unstalled IF/ID inserts a bubble rather than re-latching the same word.
            if (active && !stall_fetch) begin
                if (pc_write && state_q == RUN && !imem_data[15]) begin
                    instr_d = imem_data;
                    imm_d   = 16'h0;
                    ipc_d   = pc_inc;
                    valid_d = 1'b1;
                end else if (pc_write && state_q == IMM) begin
                    instr_d = pend_q;
                    imm_d   = imem_data;
                    ipc_d   = pc_inc;
                    valid_d = 1'b1;
                end else begin
                    instr_d = 16'h0;
                    imm_d   = 16'h0;
                    ipc_d   = 32'h0;
                    valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= BOOT_HI;
            pc_q    <= 32'h0;
            pend_q  <= 16'h0;
            instr_q <= 16'h0;
            imm_q   <= 16'h0;
            ipc_q   <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            instr_q <= instr_d;
            imm_q   <= imm_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
        end
    end

    assign if_id_instr  = instr_q;
    assign if_id_imm    = imm_q;
    assign if_id_pc     = ipc_q;
    assign if_id_valid  = valid_q;
    assign R_dest_fetch = instr_q[10:7];
    assign R_src_fetch  = instr_q[6:3];
    assign halted       = (state_q == HALTED);

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] bub_q, bub_d;

    // Counts cycles whose IF/ID result is a bubble or a held stall; saturates.
    always_comb begin
        bub_d = (active && (stall_fetch || !valid_d) && bub_q != 16'hFFFF) ? bub_q + 16'd1 : bub_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) bub_q <= 16'h0;
        else        bub_q <= bub_d;
    end

    assign bubble_count = bub_q;
`else
    assign bubble_count = 16'h0;
`endif
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset: synchronous and active-low.
REQ-003 SHALL have port pc_write, input, 1, 0 freezes the PC and FSM.
REQ-004 SHALL have port stall_fetch, input, 1, 1 freezes the IF/ID outputs.
REQ-005 SHALL have port flush_fetch, input, 1, 1 clears IF/ID and redirects the PC.
REQ-006 SHALL have port branch_target, input, 32, redirect address used on flush.
REQ-007 SHALL have port imem_addr, output, 32, word address to instruction memory; read data returns combinationally the same cycle.
REQ-008 SHALL have port imem_data, input, 16, instruction word at imem_addr.
REQ-009 SHALL have port if_id_instr, output, 16, latched instruction; NOP = 16'h0000.
REQ-010 SHALL have port if_id_imm, output, 16, latched immediate word; 0 if none.
REQ-011 SHALL have port if_id_pc, output, 32, address following the latched instruction.
REQ-012 SHALL have port if_id_valid, output, 1, IF/ID holds a real instruction.
REQ-013 SHALL have ports R_dest_fetch and R_src_fetch, output, 4 each, = if_id_instr[10:7] and [6:3]; these feed hazard detection.
REQ-014 SHALL have port halted, output, 1, high in HALTED state.
REQ-015 SHALL have port bubble_count, output, 16, performance counter (see Configuration).

Function
REQ-016 SHALL implement states BOOT_HI, BOOT_LO, RUN, IMM, HALTED.
REQ-017 BOOT_HI SHALL drive imem_addr=0, latch imem_data into PC[31:16], then go to BOOT_LO.
REQ-018 BOOT_LO SHALL drive imem_addr=1, latch imem_data into PC[15:0], then go to RUN; if_id_valid SHALL be 0 throughout boot.
REQ-019 In RUN and IMM, imem_addr SHALL equal PC.
REQ-020 RUN with a single-word instruction (imem_data[15]=0) SHALL latch IF/ID as {instr=imem_data, imm=0, pc=PC+1, valid=1} and set PC to PC+1 (1-cycle latency).
REQ-021 RUN with imem_data[15]=1 SHALL save the word to a pending register, set PC to PC+1, load an IF/ID bubble (valid=0, instr=0), and go to IMM.
REQ-022 IMM SHALL latch IF/ID as {instr=pending, imm=imem_data, pc=PC+1, valid=1}, set PC to PC+1, and return to RUN; a two-word instruction takes 2 cycles.
REQ-023 In RUN, imem_data[15:11]=5'b00001 (HLT) SHALL latch normally and go to HALTED; HALTED SHALL hold PC and load bubbles.
REQ-024 Priority SHALL be rst_n=0 > flush_fetch > pc_write/stall_fetch > normal advance.
REQ-025 flush_fetch=1 in RUN, IMM or HALTED SHALL set PC to branch_target, load an IF/ID bubble, discard pending, and go to RUN, regardless of pc_write and stall_fetch; it exits HALTED because the HLT was speculative.
REQ-026 flush_fetch SHALL be ignored in BOOT_HI and BOOT_LO.
REQ-027 pc_write=0 SHALL hold PC, pending and state; stall_fetch=1 SHALL hold all if_id_* outputs; each acts independently.
REQ-028 PC+1 SHALL wrap from 32'hFFFFFFFF to 0 with no flag.

Reset
REQ-029 While rst_n=0 at a clock edge: PC=0, state=BOOT_HI, pending=0, if_id_instr=0, if_id_imm=0, if_id_pc=0, if_id_valid=0, bubble_count=0.
REQ-030 Reset asserted mid-operation (any state, including IMM with a pending word) SHALL discard all state and restart boot in BOOT_HI.

Configuration
REQ-031 With macro FETCH_PERF_CNT_EN defined, bubble_count SHALL increment each cycle in RUN, IMM or HALTED where the newly loaded IF/ID has valid=0 or is held by stall_fetch, saturating at 16'hFFFF.
REQ-032 Without FETCH_PERF_CNT_EN, bubble_count SHALL be constant 0 and no counter logic is built.

Verification
REQ-033 Boot: mem[0]=16'h0000, mem[1]=16'h0010 -> after 2 cycles imem_addr=32'h10, state RUN, if_id_valid=0 during boot.
REQ-034 Two-word: mem[0x10]=16'h8123, mem[0x11]=16'hBEEF -> one bubble, then instr=16'h8123, imm=16'hBEEF, pc=32'h12, valid=1.
REQ-035 Stall: pc_write=0 and stall_fetch=1 held 3 cycles -> PC and IF/ID unchanged; with the macro, bubble_count +3.
REQ-036 Flush in IMM with branch_target=32'h40 -> next cycle PC=32'h40, valid=0, pending dropped, state RUN.
REQ-037 HLT fetched, then flush with target 32'h20 -> halted drops, PC=32'h20; rst_n=0 in IMM -> next state BOOT_HI, all outputs 0.
